// File: rtl/qsm_readout_seq_if.sv
// Front-end read port and readout SRAM write port of the QSM readout sequencer.
interface qsm_readout_seq_if;
  logic        ext_req_o;
  logic [3:0]  ext_dim_o;
  logic [3:0]  ext_adr_o;
  logic        ext_ack_i;
  logic [15:0] ext_data_i;
  logic        mem_we_o;
  logic [6:0]  mem_addr_o;
  logic [15:0] mem_data_o;

  modport master (
    output ext_req_o, ext_dim_o, ext_adr_o, mem_we_o, mem_addr_o, mem_data_o,
    input  ext_ack_i, ext_data_i
  );

  modport slave (
    input  ext_req_o, ext_dim_o, ext_adr_o, mem_we_o, mem_addr_o, mem_data_o,
    output ext_ack_i, ext_data_i
  );
endinterface

// File: rtl/qsm_readout_seq.sv
// Walks dim x reg space: one-cycle request to the front end, waits for ack
// with a timeout, and writes each returned word into the readout SRAM.
module qsm_readout_seq (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       reset_i,
  input  logic       trig_i,
  input  logic [3:0] last_reg_adr_i,
  input  logic [3:0] max_dim_no_i,
  input  logic [9:0] read_delay_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_many_o,
  output logic       err_fb_o,
  output logic [3:0] dim_count_o,
  qsm_readout_seq_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_STORE, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic [3:0]  dim_q, dim_d;
  logic [3:0]  ridx_q, ridx_d;
  logic [9:0]  wcnt_q, wcnt_d;
  logic [3:0]  last_sh_q, last_sh_d;
  logic [3:0]  max_sh_q, max_sh_d;
  logic [9:0]  dly_sh_q, dly_sh_d;

  logic        busy_d, done_d, err_many_d, err_fb_d;
  logic [3:0]  dcnt_d;
  logic        ext_req_d;
  logic [3:0]  ext_dim_d, ext_adr_d;
  logic        mem_we_d;
  logic [6:0]  mem_addr_d;
  logic [15:0] mem_data_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      dim_q          <= '0;
      ridx_q         <= '0;
      wcnt_q         <= '0;
      last_sh_q      <= '0;
      max_sh_q       <= '0;
      dly_sh_q       <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_many_o     <= 1'b0;
      err_fb_o       <= 1'b0;
      dim_count_o    <= '0;
      bus.ext_req_o  <= 1'b0;
      bus.ext_dim_o  <= '0;
      bus.ext_adr_o  <= '0;
      bus.mem_we_o   <= 1'b0;
      bus.mem_addr_o <= '0;
      bus.mem_data_o <= '0;
    end else begin
      state_q        <= state_d;
      dim_q          <= dim_d;
      ridx_q         <= ridx_d;
      wcnt_q         <= wcnt_d;
      last_sh_q      <= last_sh_d;
      max_sh_q       <= max_sh_d;
      dly_sh_q       <= dly_sh_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      err_many_o     <= err_many_d;
      err_fb_o       <= err_fb_d;
      dim_count_o    <= dcnt_d;
      bus.ext_req_o  <= ext_req_d;
      bus.ext_dim_o  <= ext_dim_d;
      bus.ext_adr_o  <= ext_adr_d;
      bus.mem_we_o   <= mem_we_d;
      bus.mem_addr_o <= mem_addr_d;
      bus.mem_data_o <= mem_data_d;
    end
  end

  // Outputs are computed one state ahead so ext_req_o is high exactly while
  // in REQ and mem_we_o exactly while in STORE.
  always_comb begin
    state_d    = state_q;
    dim_d      = dim_q;
    ridx_d     = ridx_q;
    wcnt_d     = wcnt_q;
    last_sh_d  = last_sh_q;
    max_sh_d   = max_sh_q;
    dly_sh_d   = dly_sh_q;
    done_d     = done_o;
    err_many_d = err_many_o;
    err_fb_d   = err_fb_o;
    dcnt_d     = dim_count_o;
    ext_req_d  = 1'b0;
    ext_dim_d  = bus.ext_dim_o;
    ext_adr_d  = bus.ext_adr_o;
    mem_we_d   = 1'b0;
    mem_addr_d = bus.mem_addr_o;
    mem_data_d = bus.mem_data_o;

    case (state_q)
      S_IDLE: begin
        if (trig_i) begin
          last_sh_d  = last_reg_adr_i;
          max_sh_d   = max_dim_no_i;
          dly_sh_d   = read_delay_i;
          done_d     = 1'b0;
          err_many_d = 1'b0;
          err_fb_d   = 1'b0;
          dcnt_d     = '0;
          dim_d      = '0;
          ridx_d     = '0;
          if (max_dim_no_i > 4'd7) err_many_d = 1'b1;
          else                     state_d    = S_REQ;
        end
      end
      S_REQ: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ack wins over timeout, so delay=0 still accepts a first-cycle ack.
        if (bus.ext_ack_i) begin
          mem_we_d   = 1'b1;
          mem_addr_d = {dim_q[2:0], ridx_q};
          mem_data_d = bus.ext_data_i;
          state_d    = S_STORE;
        end else if (wcnt_q == dly_sh_q) begin
          err_fb_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 10'd1;
        end
      end
      S_STORE: begin
        if (ridx_q < last_sh_q) begin
          ridx_d  = ridx_q + 4'd1;
          state_d = S_REQ;
        end else begin
          ridx_d = '0;
          dcnt_d = dim_q + 4'd1;
          if (dim_q == max_sh_q) begin
            state_d = S_FINISH;
          end else begin
            dim_d   = dim_q + 4'd1;
            state_d = S_REQ;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (reset_i) begin
      state_d    = S_IDLE;
      done_d     = 1'b0;
      err_many_d = 1'b0;
      err_fb_d   = 1'b0;
      dcnt_d     = '0;
      mem_we_d   = 1'b0;
      mem_addr_d = bus.mem_addr_o;
      mem_data_d = bus.mem_data_o;
    end else if (state_d == S_REQ) begin
      ext_req_d = 1'b1;
      ext_dim_d = dim_d;
      ext_adr_d = ridx_d;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_qsm_readout_seq.sv
// Directed bench for qsm_readout_seq with a front-end responder and SRAM write monitor.
module tb_qsm_readout_seq;
  logic       clk = 1'b0;
  logic       rst, soft_rst, trig;
  logic [3:0] last_reg, max_dim;
  logic [9:0] rd_dly;
  logic       busy, done, err_many, err_fb;
  logic [3:0] dim_count;

  always #5 clk = ~clk;

  qsm_readout_seq_if bus();

  qsm_readout_seq dut (
    .clk_i(clk), .rst_i(rst), .reset_i(soft_rst), .trig_i(trig),
    .last_reg_adr_i(last_reg), .max_dim_no_i(max_dim), .read_delay_i(rd_dly),
    .busy_o(busy), .done_o(done), .err_many_o(err_many), .err_fb_o(err_fb),
    .dim_count_o(dim_count), .bus(bus)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // monitor: sole writer of the activity counters and write log
  int          wr_cnt = 0, req_cnt = 0, busy_cyc = 0;
  logic [6:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  initial forever begin
    @(negedge clk);
    if (bus.mem_we_o) begin
      wr_cnt++;
      wr_addr.push_back(bus.mem_addr_o);
      wr_data.push_back(bus.mem_data_o);
    end
    if (bus.ext_req_o) req_cnt++;
    if (busy) busy_cyc++;
  end

  // front end: acks ack_dly cycles after a request with data {C0, dim, adr}
  int         ack_dly = 1;
  bit         ack_en = 1'b1;
  int         cd = 0;
  logic [3:0] ld, la;
  initial begin
    bus.ext_ack_i  = 1'b0;
    bus.ext_data_i = '0;
    forever begin
      @(negedge clk);
      bus.ext_ack_i = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.ext_ack_i  = 1'b1;
          bus.ext_data_i = {8'hC0, ld, la};
        end
      end
      if (bus.ext_req_o && ack_en) begin
        cd = ack_dly;
        ld = bus.ext_dim_o;
        la = bus.ext_adr_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [3:0] lr, input logic [3:0] md, input logic [9:0] dl);
    last_reg = lr; max_dim = md; rd_dly = dl;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int c = 0;
    tick();
    while (busy && c < maxc) begin
      tick();
      c++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_req(input int maxc, input string tag);
    int c = 0;
    while (!bus.ext_req_o && c < maxc) begin
      tick();
      c++;
    end
    chk(tag, {31'd0, bus.ext_req_o}, 32'd1);
  endtask

  logic [6:0]  nom_a [4] = '{7'h00, 7'h01, 7'h10, 7'h11};
  logic [15:0] nom_d [4] = '{16'hC000, 16'hC001, 16'hC010, 16'hC011};

  initial begin
    int b, rb, bc, c, bad;
    rst = 1'b1; soft_rst = 1'b0; trig = 1'b0;
    last_reg = '0; max_dim = '0; rd_dly = '0;
    tick(2);
    chk("rst_flags", {23'd0, busy, done, err_many, err_fb, dim_count}, 32'd0);
    chk("rst_ext", {23'd0, bus.ext_req_o, bus.ext_dim_o, bus.ext_adr_o}, 32'd0);
    chk("rst_mem", {8'd0, bus.mem_we_o, bus.mem_addr_o, bus.mem_data_o}, 32'd0);
    rst = 1'b0;
    tick();

    // nominal 2x2 run
    ack_dly = 2; b = wr_cnt; rb = req_cnt;
    start(4'd1, 4'd1, 10'd5);
    chk("nom_busy", {31'd0, busy}, 32'd1);
    wait_idle(100, "nom_timeout");
    chk("nom_wr", wr_cnt - b, 4);
    chk("nom_req", req_cnt - rb, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("nom_addr%0d", i), (b + i < wr_addr.size()) ? {25'd0, wr_addr[b+i]} : 32'hx, {25'd0, nom_a[i]});
      chk($sformatf("nom_data%0d", i), (b + i < wr_data.size()) ? {16'd0, wr_data[b+i]} : 32'hx, {16'd0, nom_d[i]});
    end
    chk("nom_done", {31'd0, done}, 32'd1);
    chk("nom_dcnt", {28'd0, dim_count}, 32'd2);
    chk("nom_errfb", {31'd0, err_fb}, 32'd0);

    // ack timeout
    ack_en = 1'b0; b = wr_cnt;
    start(4'd0, 4'd0, 10'd3);
    wait_req(10, "to_req");
    tick(4);
    chk("to_early", {31'd0, err_fb}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("to_err", {31'd0, err_fb}, 32'd1);
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_done", {31'd0, done}, 32'd0);
    chk("to_wr", wr_cnt - b, 0);
    ack_en = 1'b1;

    // too many dimensions
    b = wr_cnt; rb = req_cnt; bc = busy_cyc;
    start(4'd0, 4'd8, 10'd3);
    tick(3);
    chk("many_err", {31'd0, err_many}, 32'd1);
    chk("many_busy", busy_cyc - bc, 0);
    chk("many_req", req_cnt - rb, 0);
    chk("many_errfb", {31'd0, err_fb}, 32'd0);

    // soft reset in WAIT of dim 0, reg 2
    ack_dly = 3; b = wr_cnt;
    start(4'd3, 4'd1, 10'd10);
    c = 0;
    while (!(bus.ext_req_o && bus.ext_adr_o == 4'd2) && c < 50) begin
      tick();
      c++;
    end
    chk("sr_req2", {31'd0, bus.ext_req_o}, 32'd1);
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("sr_flags", {23'd0, busy, done, err_many, err_fb, dim_count}, 32'd0);
    tick(6);
    chk("sr_wr", wr_cnt - b, 2);
    chk("sr_idle", {31'd0, busy}, 32'd0);
    ack_dly = 1; b = wr_cnt;
    start(4'd0, 4'd0, 10'd2);
    wait_idle(50, "sr2_timeout");
    chk("sr2_addr", (b < wr_addr.size()) ? {25'd0, wr_addr[b]} : 32'hx, 32'h00);
    chk("sr2_data", (b < wr_data.size()) ? {16'd0, wr_data[b]} : 32'hx, 32'hC000);
    chk("sr2_done", {31'd0, done}, 32'd1);

    // boundary: full 8x16 sweep with zero delay
    ack_dly = 1; b = wr_cnt;
    start(4'd15, 4'd7, 10'd0);
    wait_idle(1000, "bnd_timeout");
    chk("bnd_wr", wr_cnt - b, 128);
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (b + i >= wr_addr.size()) bad++;
      else if (wr_addr[b+i] != i[6:0] || wr_data[b+i] != {9'h180, i[6:0]}) bad++;
    end
    chk("bnd_bad", bad, 0);
    chk("bnd_dcnt", {28'd0, dim_count}, 32'd8);
    chk("bnd_done", {31'd0, done}, 32'd1);

    // trig and soft reset together
    rb = req_cnt;
    last_reg = 4'd0; max_dim = 4'd0; rd_dly = 10'd5;
    soft_rst = 1'b1; trig = 1'b1;
    tick();
    soft_rst = 1'b0; trig = 1'b0;
    chk("tr_busy", {31'd0, busy}, 32'd0);
    chk("tr_done", {31'd0, done}, 32'd0);
    tick(3);
    chk("tr_req", req_cnt - rb, 0);

    // trig while busy is ignored
    ack_dly = 2; rb = req_cnt;
    start(4'd1, 4'd0, 10'd5);
    tick(2);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    wait_idle(100, "tb_timeout");
    chk("tb_req", req_cnt - rb, 2);
    chk("tb_done", {31'd0, done}, 32'd1);

    // rst during STORE of address 0x01
    ack_dly = 2;
    start(4'd1, 4'd1, 10'd5);
    c = 0;
    while (!(bus.mem_we_o && bus.mem_addr_o == 7'h01) && c < 50) begin
      tick();
      c++;
    end
    chk("ms_we_seen", {31'd0, bus.mem_we_o}, 32'd1);
    rst = 1'b1;
    tick();
    chk("ms_we", {31'd0, bus.mem_we_o}, 32'd0);
    chk("ms_mem", {9'd0, bus.mem_addr_o, bus.mem_data_o}, 32'd0);
    chk("ms_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/qsm_readout_seq.md
QSM_READOUT_SEQ -- requirements
Module: qsm_readout_seq

Interface
REQ-001 The module SHALL have the following ports. Clock and reset come first. There is one clock. Reset is synchronous and active-high.
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- reset_i  in  1  soft-reset pulse from the control register
- trig_i  in  1  start pulse from the control register
- last_reg_adr_i  in  4  last register index to read in each dimension
- max_dim_no_i  in  4  last dimension index to read
- read_delay_i  in  10  ack timeout, in cycles
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence completed without error
- err_many_o  out  1  too many dimensions requested
- err_fb_o  out  1  front-end ack timeout
- dim_count_o  out  4  number of dimensions completed
- ext_req_o  out  1  one-cycle read request to the front end
- ext_dim_o  out  4  dimension index of the request
- ext_adr_o  out  4  register index of the request
- ext_ack_i  in  1  front-end data valid
- ext_data_i  in  16  front-end read data
- mem_we_o  out  1  readout SRAM write enable
- mem_addr_o  out  7  readout SRAM word address
- mem_data_o  out  16  readout SRAM write data

Function
REQ-002 The state machine SHALL have the states IDLE, REQ, WAIT, STORE and FINISH.
REQ-003 In IDLE, when trig_i=1 and reset_i=0:
- latch last_reg_adr_i, max_dim_no_i and read_delay_i into shadow registers;
- clear done_o, err_many_o, err_fb_o and dim_count_o;
- set the dim and reg counters to 0.
REQ-004 On trig, if max_dim_no_i>7 the block SHALL set err_many_o=1, stay in IDLE and perform no front-end or SRAM access.
REQ-005 Otherwise the next state SHALL be REQ, and busy_o SHALL be 1 from the cycle after trig until the cycle after FINISH or an abort.
REQ-006 In REQ, the block SHALL drive ext_req_o=1 for exactly one cycle, with ext_dim_o=dim and ext_adr_o=reg, then go to WAIT with the wait counter at 0.
REQ-007 In WAIT, if ext_ack_i=1 the block SHALL capture ext_data_i and go to STORE.
REQ-008 In WAIT, if ext_ack_i=0 and the wait counter equals the shadow read_delay, the block SHALL:
- set err_fb_o=1;
- return to IDLE without writing the SRAM.
REQ-009 In WAIT, if neither REQ-007 nor REQ-008 applies, the wait counter SHALL increment by 1.
REQ-010 With read_delay=0, an ack is accepted only in the first WAIT cycle.
REQ-011 ext_ack_i SHALL be ignored in every state except WAIT.
REQ-012 In STORE, the block SHALL drive the following for exactly one cycle:
- mem_we_o=1;
- mem_addr_o={dim[2:0], reg[3:0]};
- mem_data_o = the captured word.
REQ-013 After STORE:
- if reg<last_reg_adr: reg increments and the next state is REQ;
- else: reg=0, dim_count_o=dim+1, and then if dim=max_dim_no the next state is FINISH, else dim increments and the next state is REQ.
REQ-014 FINISH SHALL last one cycle, set done_o=1 and return to IDLE.
REQ-015 done_o, err_fb_o, err_many_o and dim_count_o SHALL hold until the next accepted trig, reset_i or rst_i.
REQ-016 trig_i SHALL be ignored in every state except IDLE.
REQ-017 A reset_i=1 in any state SHALL, on the next edge:
- force IDLE;
- clear busy_o, done_o, both error flags and dim_count_o;
- suppress any pending mem_we_o or ext_req_o.
REQ-018 If reset_i and trig_i are both 1 in the same cycle, reset_i SHALL win and the trig SHALL be discarded.
REQ-019 When mem_we_o=0 and ext_req_o=0, mem_addr_o, mem_data_o, ext_dim_o and ext_adr_o SHALL hold their last values.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 On rst_i=1 all of the following SHALL be 0 on the next edge, and the state SHALL be IDLE:
- state outputs: busy_o, done_o, err_many_o, err_fb_o, dim_count_o;
- front-end outputs: ext_req_o, ext_dim_o, ext_adr_o;
- SRAM outputs: mem_we_o, mem_addr_o, mem_data_o;
- internal counters and shadow registers.
REQ-022 rst_i SHALL take priority over reset_i and trig_i.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Nominal run: last_reg_adr=1, max_dim_no=1, delay=5, ack 2 cycles after each req -> 4 writes to addresses 0x00, 0x01, 0x10, 0x11 with data matching; done_o=1; dim_count_o=2; busy_o then 0.
- Timeout: delay=3, no ack -> err_fb_o=1 exactly 4 WAIT cycles after req; no mem_we_o; busy_o=0; done_o=0.
- Too many dimensions: max_dim_no=8, trig -> err_many_o=1; busy_o never 1; no ext_req_o.
- Soft reset mid-run: reset_i asserted during the WAIT of dimension 0, register 2 -> IDLE; all flags 0; no further writes; a later trig restarts at address 0x00.
- Boundary: last_reg_adr=15, max_dim_no=7, delay=0, ack in the first WAIT cycle -> 128 writes covering 0x00..0x7F; dim_count_o=8; done_o=1.
- Trig and reset_i together: trig and reset_i in the same cycle -> stays IDLE; a trig while busy is ignored (checked by request count); rst_i mid-STORE -> mem_we_o=0 on the next edge.
